ly_pulse_stretch: RTL and testbench

- Per-wire pulse extender for one anode layer; the opposite operation to the layer one-shot stage.
- Takes single-clock hit pulses (one-shot output) and stretches each to a programmable width, modelling the drift-time coincidence window.
- Sits between the layer one-shot stage and the pattern finder.
- Also provides a registered layer-OR flag and a saturating per-layer hit counter for rate monitoring.

---
 rtl/ly_pulse_stretch_pkg.sv | 19 +
 rtl/ly_pulse_stretch_if.sv | 24 ++
 rtl/ly_pulse_stretch_wire_stretch.sv | 43 ++++
 rtl/ly_pulse_stretch.sv | 53 +++++
 tb/tb_ly_pulse_stretch.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/ly_pulse_stretch_pkg.sv
// Shared constants and helpers for the anode-layer pulse stretcher.
// Saturating add keeps one guard bit so overflow is detected in a single adder.
package ly_pkg;

    localparam int LY_WIDTH = 112;
    localparam int CNT_W    = 3;
    localparam int HCNT_W   = 16;
    localparam int POP_W    = $clog2(LY_WIDTH + 1);

    function automatic logic [HCNT_W-1:0] sat_add(
        input logic [HCNT_W-1:0] acc,
        input logic [POP_W-1:0]  inc
    );
        logic [HCNT_W:0] w_sum;
        w_sum = {1'b0, acc} + (HCNT_W+1)'(inc);
        return w_sum[HCNT_W] ? {HCNT_W{1'b1}} : w_sum[HCNT_W-1:0];
    endfunction

endpackage

// File: rtl/ly_pulse_stretch_if.sv
// Signal bundle between the layer one-shot stage, the stretcher and the pattern finder.
// No valid/ready: every signal is sampled or updated on every rising clock edge.
interface ly_pulse_stretch_if;
    import ly_pkg::*;

    logic [LY_WIDTH-1:0] lyr;
    logic [CNT_W-1:0]    ext_len;
    logic                trig_stop;
    logic                hcnt_clr;
    logic [LY_WIDTH-1:0] lys;
    logic                ly_any;
    logic [HCNT_W-1:0]   hcnt;

    modport master (
        output lyr, ext_len, trig_stop, hcnt_clr,
        input  lys, ly_any, hcnt
    );

    modport slave (
        input  lyr, ext_len, trig_stop, hcnt_clr,
        output lys, ly_any, hcnt
    );

endinterface

// File: rtl/ly_pulse_stretch_wire_stretch.sv
// One wire of the stretcher: a down-counter holding the remaining extension and the output flop.
// lys_next is exposed so the layer OR can be registered on the same edge as lys.
module wire_stretch
    import ly_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             hit,
    input  logic [CNT_W-1:0] ext_len,
    output logic             lys_next,
    output logic             lys
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_lys;

    // A hit always reloads, so a retrigger mid-window restarts it with the current ext_len.
    always_comb begin
        w_cnt_next = r_cnt;
        lys_next   = 1'b0;
        if (hit) begin
            w_cnt_next = ext_len;
            lys_next   = 1'b1;
        end else if (r_cnt != '0) begin
            w_cnt_next = r_cnt - 1'b1;
            lys_next   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_lys <= 1'b0;
        end else begin
            r_cnt <= w_cnt_next;
            r_lys <= lys_next;
        end
    end

    assign lys = r_lys;

endmodule

// File: rtl/ly_pulse_stretch.sv
// Layer pulse stretcher: per-wire extenders, registered layer-OR and a saturating hit counter.
// trig_stop only masks new hits; windows already running drain on their own.
module ly_pulse_stretch
    import ly_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    ly_pulse_stretch_if.slave  bus
);

    logic [LY_WIDTH-1:0] w_accept;
    logic [LY_WIDTH-1:0] w_lys_next;
    logic [LY_WIDTH-1:0] w_lys;
    logic [POP_W-1:0]    w_pop;
    logic                r_ly_any;
    logic [HCNT_W-1:0]   r_hcnt;

    assign w_accept = bus.lyr & ~{LY_WIDTH{bus.trig_stop}};

    for (genvar g = 0; g < LY_WIDTH; g++) begin : g_wire
        wire_stretch u_wire (
            .clk      (clk),
            .rst      (rst),
            .hit      (w_accept[g]),
            .ext_len  (bus.ext_len),
            .lys_next (w_lys_next[g]),
            .lys      (w_lys[g])
        );
    end

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < LY_WIDTH; i++) begin
            w_pop = w_pop + POP_W'(w_accept[i]);
        end
    end

    // Clear wins over the increment, so hits landing on the clear clock are discarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ly_any <= 1'b0;
            r_hcnt   <= '0;
        end else begin
            r_ly_any <= |w_lys_next;
            r_hcnt   <= bus.hcnt_clr ? '0 : sat_add(r_hcnt, w_pop);
        end
    end

    assign bus.lys    = w_lys;
    assign bus.ly_any = r_ly_any;
    assign bus.hcnt   = r_hcnt;

endmodule

// File: tb/tb_ly_pulse_stretch.sv
// Bench for ly_pulse_stretch: directed scenarios plus random traffic against an
// end-of-window reference model (each wire remembers the last cycle it must stay high).
module tb_ly_pulse_stretch;
    import ly_pkg::*;

    logic clk;
    logic rst;

    ly_pulse_stretch_if bus ();

    ly_pulse_stretch dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int exp_end [LY_WIDTH];
    int hcnt_m;
    int cyc;

    int watch_bit;
    int hi_cnt;

    localparam int HMAX = (1 << HCNT_W) - 1;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < LY_WIDTH; i++) exp_end[i] = -1;
        hcnt_m = 0;
    endtask

    // Apply inputs, take one edge, advance the model and compare all outputs.
    task automatic step(input logic [LY_WIDTH-1:0] l, input int ext, input logic ts, input logic clr);
        logic [LY_WIDTH-1:0] exp_lys;
        int pop;
        bus.lyr       = l;
        bus.ext_len   = CNT_W'(ext);
        bus.trig_stop = ts;
        bus.hcnt_clr  = clr;
        @(posedge clk);
        cyc++;
        pop = 0;
        for (int i = 0; i < LY_WIDTH; i++) begin
            if (l[i] && !ts) begin
                exp_end[i] = cyc + ext;
                pop++;
            end
        end
        if (clr) hcnt_m = 0;
        else     hcnt_m = (hcnt_m + pop > HMAX) ? HMAX : hcnt_m + pop;
        for (int i = 0; i < LY_WIDTH; i++) exp_lys[i] = (exp_end[i] >= cyc);
        @(negedge clk);
        check_val("lys", 128'(bus.lys), 128'(exp_lys));
        check_val("ly_any", 128'(bus.ly_any), 128'(|exp_lys));
        check_val("hcnt", 128'(bus.hcnt), 128'(hcnt_m));
        if (bus.lys[watch_bit]) hi_cnt++;
    endtask

    task automatic idle(input int n, input int ext);
        for (int k = 0; k < n; k++) step('0, ext, 1'b0, 1'b0);
    endtask

    function automatic logic [LY_WIDTH-1:0] one_hot(input int b);
        logic [LY_WIDTH-1:0] v;
        v = '0;
        v[b] = 1'b1;
        return v;
    endfunction

    initial begin
        logic [LY_WIDTH-1:0] rv;
        int e_list [3];
        e_list[0] = 0; e_list[1] = 3; e_list[2] = 7;
        cyc = 0;
        watch_bit = 0;
        hi_cnt = 0;
        model_reset();
        bus.lyr = '0; bus.ext_len = '0; bus.trig_stop = 1'b0; bus.hcnt_clr = 1'b0;
        rst = 1'b1;
        #1;
        check_val("rst_lys", 128'(bus.lys), 128'(0));
        check_val("rst_any", 128'(bus.ly_any), 128'(0));
        check_val("rst_hcnt", 128'(bus.hcnt), 128'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Width sweep on wire 0
        for (int j = 0; j < 3; j++) begin
            step('0, 0, 1'b0, 1'b1);
            watch_bit = 0; hi_cnt = 0;
            step(one_hot(0), e_list[j], 1'b0, 1'b0);
            idle(10, e_list[j]);
            check_val($sformatf("width_e%0d", e_list[j]), 128'(hi_cnt), 128'(e_list[j] + 1));
            check_val("width_hcnt", 128'(bus.hcnt), 128'(1));
        end

        // Retrigger on wire 111
        step('0, 0, 1'b0, 1'b1);
        watch_bit = 111; hi_cnt = 0;
        step(one_hot(111), 3, 1'b0, 1'b0);
        step('0, 3, 1'b0, 1'b0);
        step(one_hot(111), 3, 1'b0, 1'b0);
        idle(8, 3);
        check_val("retrig_width", 128'(hi_cnt), 128'(6));
        check_val("retrig_hcnt", 128'(bus.hcnt), 128'(2));

        // trig_stop drops hits but lets the active window drain
        step('0, 0, 1'b0, 1'b1);
        watch_bit = 50; hi_cnt = 0;
        step(one_hot(50), 4, 1'b0, 1'b0);
        for (int k = 1; k <= 10; k++) step((k == 3) ? one_hot(50) : '0, 4, 1'b1, 1'b0);
        idle(4, 4);
        check_val("tstop_width", 128'(hi_cnt), 128'(5));
        check_val("tstop_hcnt", 128'(bus.hcnt), 128'(1));

        // ext_len change mid-stretch
        watch_bit = 9; hi_cnt = 0;
        step(one_hot(9), 6, 1'b0, 1'b0);
        step('0, 6, 1'b0, 1'b0);
        idle(9, 1);
        check_val("extchg_keep", 128'(hi_cnt), 128'(7));
        hi_cnt = 0;
        step(one_hot(9), 1, 1'b0, 1'b0);
        idle(4, 1);
        check_val("extchg_new", 128'(hi_cnt), 128'(2));

        // Held-high input
        watch_bit = 20; hi_cnt = 0;
        repeat (4) step(one_hot(20), 2, 1'b0, 1'b0);
        idle(5, 2);
        check_val("held_width", 128'(hi_cnt), 128'(6));

        // Popcount and saturation
        step('0, 0, 1'b0, 1'b1);
        step('1, 2, 1'b0, 1'b0);
        check_val("pop_112", 128'(bus.hcnt), 128'(112));
        repeat (599) step('1, 2, 1'b0, 1'b0);
        check_val("sat_hcnt", 128'(bus.hcnt), 128'(HMAX));
        step('1, 2, 1'b0, 1'b0);
        check_val("sat_hold", 128'(bus.hcnt), 128'(HMAX));
        step('0, 2, 1'b0, 1'b1);
        check_val("clr_hcnt", 128'(bus.hcnt), 128'(0));
        idle(4, 0);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < LY_WIDTH; i++) rv[i] = ($urandom_range(0, 15) == 0);
            step(rv, $urandom_range(0, 7), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 31) == 0));
        end

        // Reset mid-stretch
        step('0, 0, 1'b0, 1'b1);
        step(one_hot(7), 5, 1'b0, 1'b0);
        step('0, 5, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        model_reset();
        check_val("mrst_lys", 128'(bus.lys), 128'(0));
        check_val("mrst_any", 128'(bus.ly_any), 128'(0));
        check_val("mrst_hcnt", 128'(bus.hcnt), 128'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        watch_bit = 7; hi_cnt = 0;
        idle(8, 5);
        check_val("mrst_after", 128'(hi_cnt), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
